lut_cfg_loader: RTL and testbench

Configuration writer and read port for one K-input LUT cell. It accepts the 2^K-bit truth-table mask as a serial bit stream over a valid/ready handshake, checks an even-parity trailer, and commits the mask atomically. The committed mask drives the LUT output that the fabric reads through A/OUT. It sits between the configuration controller's serial chain and each LUT instance.

---
 rtl/lut_cfg_pkg.sv | 25 ++
 rtl/lut_cell.sv | 30 +++
 rtl/lut_cfg_loader.sv | 138 +++++++++++++
 tb/tb_lut_cfg_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader and its LUT cell.
// Supports K up to 8, so a mask is at most 256 bits wide.
package lut_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      PARITY = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_t;

   localparam int MAX_MASK_W = 256;

   function automatic int mask_w(input int k);
      return 2 ** k;
   endfunction

   // Narrower masks are zero-extended by the caller, which leaves parity unchanged.
   // Returns 1 when the mask together with the trailer bit has even parity.
   function automatic logic even_parity(input logic [MAX_MASK_W-1:0] mask, input logic trailer);
      return ~(^mask ^ trailer);
   endfunction

endpackage

// File: rtl/lut_cell.sv
// One K-input LUT: committed truth-table mask register and the combinational read mux.
module lut_cell
   import lut_cfg_pkg::*;
#(
   parameter int K = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_en,
   input  logic [2**K-1:0]      load_data,
   input  logic [K-1:0]         a,
   output logic                 out_bit
);

   localparam int MW = mask_w(K);

   logic [MW-1:0] mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask <= '0;
      end else if (load_en) begin
         mask <= load_data;
      end
   end

   // Read path stays unregistered so the fabric sees the mask without an extra cycle.
   assign out_bit = mask[a];

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial mask loader for one LUT cell: shifts the mask in LSB first, checks the
// optional even-parity trailer and commits the whole mask in one edge.
//
//   state  | meaning
//   IDLE   | waiting for CFG_START, bits ignored
//   SHIFT  | accepting mask bits into the shadow register
//   PARITY | accepting the parity trailer bit
//   DONE   | one-cycle commit pulse on CFG_DONE
//   ERROR  | one-cycle parity-failure state, CFG_ERR raised
module lut_cfg_loader
   import lut_cfg_pkg::*;
#(
   parameter int K         = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         CFG_START,
   input  logic         CFG_BIT,
   input  logic         CFG_VALID,
   output logic         CFG_READY,
   output logic         CFG_DONE,
   output logic         CFG_ERR,
   output logic         BUSY,
   input  logic [K-1:0] A,
   output logic         OUT
);

   localparam int         MW       = mask_w(K);
   localparam logic [K:0] LAST_IDX = (K+1)'(MW - 1);

   state_t                  state, state_nxt;
   logic [K:0]              count, count_nxt;
   logic [MW-1:0]           shadow, shadow_nxt;
   logic                    err, err_nxt;
   logic                    commit;
   logic                    beat;
   logic                    last_beat;
   logic                    par_ok;
   logic [MAX_MASK_W-1:0]   par_vec;

   always_comb begin
      CFG_READY = (state == SHIFT) || (state == PARITY);
      CFG_DONE  = (state == DONE);
      BUSY      = (state != IDLE);
      CFG_ERR   = err;
   end

   assign beat      = CFG_VALID & CFG_READY;
   assign last_beat = (count == LAST_IDX);

   always_comb begin
      par_vec           = '0;
      par_vec[MW-1:0]   = shadow;
   end

   assign par_ok = even_parity(par_vec, CFG_BIT);

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      shadow_nxt = shadow;
      err_nxt    = err;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (CFG_START) begin
               state_nxt  = SHIFT;
               count_nxt  = '0;
               shadow_nxt = '0;
               err_nxt    = 1'b0;
            end
         end
         SHIFT: begin
            // A restart wins over a beat arriving in the same cycle.
            if (CFG_START) begin
               state_nxt  = SHIFT;
               count_nxt  = '0;
               shadow_nxt = '0;
            end else if (beat) begin
               shadow_nxt[count[K-1:0]] = CFG_BIT;
               count_nxt                = count + 1'b1;
               if (last_beat) begin
                  if (PARITY_EN) begin
                     state_nxt = PARITY;
                  end else begin
                     state_nxt = DONE;
                     commit    = 1'b1;
                  end
               end
            end
         end
         PARITY: begin
            if (CFG_START) begin
               state_nxt  = SHIFT;
               count_nxt  = '0;
               shadow_nxt = '0;
            end else if (beat) begin
               if (par_ok) begin
                  state_nxt = DONE;
                  commit    = 1'b1;
               end else begin
                  state_nxt = ERROR;
                  err_nxt   = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         ERROR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         count  <= '0;
         shadow <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         shadow <= shadow_nxt;
         err    <= err_nxt;
      end
   end

   // shadow_nxt already holds the final mask bit when committing straight from SHIFT.
   lut_cell #(.K(K)) u_cell (
      .clk       (CLK),
      .rst       (RST),
      .load_en   (commit),
      .load_data (shadow_nxt),
      .a         (A),
      .out_bit   (OUT)
   );

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader: parity and no-parity instances, hand-computed expectations.
module tb_lut_cfg_loader;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CFG_START, CFG_BIT, CFG_VALID;
   logic       CFG_READY, CFG_DONE, CFG_ERR, BUSY;
   logic [3:0] A;
   logic       OUT;

   logic       z_start, z_bit, z_valid;
   logic       z_ready, z_done, z_err, z_busy;
   logic [3:0] z_a;
   logic       z_out;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   lut_cfg_loader #(.K(4), .PARITY_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST), .CFG_START(CFG_START), .CFG_BIT(CFG_BIT), .CFG_VALID(CFG_VALID),
      .CFG_READY(CFG_READY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .BUSY(BUSY),
      .A(A), .OUT(OUT)
   );

   lut_cfg_loader #(.K(4), .PARITY_EN(1'b0)) dut0 (
      .CLK(CLK), .RST(RST), .CFG_START(z_start), .CFG_BIT(z_bit), .CFG_VALID(z_valid),
      .CFG_READY(z_ready), .CFG_DONE(z_done), .CFG_ERR(z_err), .BUSY(z_busy),
      .A(z_a), .OUT(z_out)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start pulse (with a junk beat alongside), 16 mask bits LSB first, then the trailer.
   // Optional 3-cycle valid gaps follow mask bits ga and gb. n counts cycles from the start cycle.
   task automatic load(input logic [15:0] m, input logic p, input int ga, input int gb,
                       output int dcyc, output logic early, output logic mid_out);
      int n;
      early     = 1'b0;
      mid_out   = 1'b0;
      CFG_START = 1'b1;
      CFG_VALID = 1'b1;
      CFG_BIT   = 1'b1;
      tick();
      n         = 1;
      CFG_START = 1'b0;
      for (int i = 0; i < 16; i++) begin
         CFG_VALID = 1'b1;
         CFG_BIT   = m[i];
         tick();
         n++;
         early |= CFG_DONE;
         if (i == 8) mid_out = OUT;
         if (i == ga || i == gb) begin
            CFG_VALID = 1'b0;
            CFG_BIT   = ~m[i];
            repeat (3) begin
               tick();
               n++;
               early |= CFG_DONE;
            end
         end
      end
      CFG_VALID = 1'b1;
      CFG_BIT   = p;
      tick();
      n++;
      CFG_VALID = 1'b0;
      CFG_BIT   = 1'b0;
      dcyc      = n;
   endtask

   initial begin
      int          dc;
      logic        early, mid;
      logic [3:0]  av;
      logic [15:0] pm;
      logic [15:0] zm;

      RST = 1'b1;
      CFG_START = 1'b0; CFG_BIT = 1'b0; CFG_VALID = 1'b0; A = 4'h0;
      z_start = 1'b0; z_bit = 1'b0; z_valid = 1'b0; z_a = 4'h0;
      repeat (3) tick();
      RST = 1'b0;
      tick();

      // Reset state
      A = 4'hF; #1;
      chk("rst_ready", 32'(CFG_READY), 32'd0);
      chk("rst_done",  32'(CFG_DONE),  32'd0);
      chk("rst_err",   32'(CFG_ERR),   32'd0);
      chk("rst_busy",  32'(BUSY),      32'd0);
      chk("rst_out",   32'(OUT),       32'd0);

      // AND4
      load(16'h8000, 1'b1, -1, -1, dc, early, mid);
      chk("and_latency", 32'(dc),       32'd18);
      chk("and_done",    32'(CFG_DONE), 32'd1);
      chk("and_early",   32'(early),    32'd0);
      chk("and_out_f",   32'(OUT),      32'd1);
      A = 4'hE; #1;
      chk("and_out_e",   32'(OUT),      32'd0);
      chk("and_err",     32'(CFG_ERR),  32'd0);
      tick();
      chk("and_done_1cyc", 32'(CFG_DONE), 32'd0);
      chk("and_busy_idle", 32'(BUSY),     32'd0);

      // XOR4 with valid gaps; A=F reads the old mask mid-load (8000 -> 1, 6996 -> 0)
      A = 4'hF;
      load(16'h6996, 1'b0, 4, 11, dc, early, mid);
      chk("xor_mid_old", 32'(mid),      32'd1);
      chk("xor_latency", 32'(dc),       32'd24);
      chk("xor_done",    32'(CFG_DONE), 32'd1);
      chk("xor_early",   32'(early),    32'd0);
      tick();
      for (int i = 0; i < 16; i++) begin
         av = 4'(i);
         A  = av; #1;
         chk("xor_sweep", 32'(OUT), 32'(^av));
      end

      // Parity error: FFFF needs trailer 0, send 1
      A = 4'h0;
      load(16'hFFFF, 1'b1, -1, -1, dc, early, mid);
      chk("perr_err",   32'(CFG_ERR),   32'd1);
      chk("perr_done",  32'(CFG_DONE),  32'd0);
      chk("perr_early", 32'(early),     32'd0);
      chk("perr_busy",  32'(BUSY),      32'd1);
      chk("perr_ready", 32'(CFG_READY), 32'd0);
      chk("perr_out0",  32'(OUT),       32'd0);
      tick();
      chk("perr_sticky", 32'(CFG_ERR),  32'd1);
      chk("perr_idle",   32'(BUSY),     32'd0);
      chk("perr_nodone", 32'(CFG_DONE), 32'd0);
      tick();
      chk("perr_sticky2", 32'(CFG_ERR), 32'd1);
      A = 4'h3; #1;
      chk("perr_out3", 32'(OUT), 32'd0);

      // Abort after 7 bits of 1234, then full 00FF
      pm = 16'h1234;
      CFG_START = 1'b1; CFG_VALID = 1'b1; CFG_BIT = 1'b1;
      tick();
      CFG_START = 1'b0;
      chk("abort_err_clr", 32'(CFG_ERR),   32'd0);
      chk("abort_busy",    32'(BUSY),      32'd1);
      chk("abort_ready",   32'(CFG_READY), 32'd1);
      for (int i = 0; i < 7; i++) begin
         CFG_BIT = pm[i];
         tick();
      end
      load(16'h00FF, 1'b0, -1, -1, dc, early, mid);
      chk("abort_latency", 32'(dc),       32'd18);
      chk("abort_done",    32'(CFG_DONE), 32'd1);
      tick();
      for (int i = 0; i < 16; i++) begin
         av = 4'(i);
         A  = av; #1;
         chk("abort_sweep", 32'(OUT), 32'(i < 8));
      end

      // Reset mid-load after 10 bits
      pm = 16'hAAAA;
      CFG_START = 1'b1; CFG_VALID = 1'b1; CFG_BIT = 1'b0;
      tick();
      CFG_START = 1'b0;
      for (int i = 0; i < 10; i++) begin
         CFG_BIT = pm[i];
         tick();
      end
      chk("rstmid_busy_pre", 32'(BUSY), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      CFG_VALID = 1'b0;
      chk("rstmid_busy",  32'(BUSY),      32'd0);
      chk("rstmid_ready", 32'(CFG_READY), 32'd0);
      chk("rstmid_err",   32'(CFG_ERR),   32'd0);
      for (int i = 0; i < 16; i++) begin
         av = 4'(i);
         A  = av; #1;
         chk("rstmid_out", 32'(OUT), 32'd0);
      end

      // PARITY_EN=0 instance: FFFE, no trailer
      zm      = 16'hFFFE;
      early   = 1'b0;
      z_start = 1'b1;
      tick();
      dc      = 1;
      z_start = 1'b0;
      chk("np_ready", 32'(z_ready), 32'd1);
      for (int i = 0; i < 16; i++) begin
         z_valid = 1'b1;
         z_bit   = zm[i];
         tick();
         dc++;
         if (i < 15) early |= z_done;
      end
      z_valid = 1'b0;
      chk("np_latency", 32'(dc),     32'd17);
      chk("np_done",    32'(z_done), 32'd1);
      chk("np_early",   32'(early),  32'd0);
      tick();
      chk("np_done_1cyc", 32'(z_done), 32'd0);
      chk("np_busy",      32'(z_busy), 32'd0);
      chk("np_err",       32'(z_err),  32'd0);
      for (int i = 0; i < 16; i++) begin
         av  = 4'(i);
         z_a = av; #1;
         chk("np_sweep", 32'(z_out), 32'(i != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
